// File: rtl/fc_layer_ctrl.sv
// Fully-connected layer sequencer.
// Walks every output neuron of a layer: clears the MAC core, streams num_in
// node/weight operand pairs from memory, waits for the core pipeline to
// drain, then holds the neuron result on a valid/ready port. Weight
// addresses step through a row-major matrix by adding num_in per neuron.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_start, i_num_in/out      start pulse and layer dimensions
//   o_idle, o_done             idle flag, one-cycle layer-complete pulse
//   o_node_ce/addr             node memory read port
//   o_wegt_ce/addr             weight memory read port
//   o_bias_addr                bias memory address (current output index)
//   o_core_run/valid/bias_en   MAC core controls
//   i_core_result              MAC core accumulator
//   o_res_valid/data/idx       neuron result port, i_res_ready accepts it
module fc_layer_ctrl #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 10,
   parameter int unsigned ADDR_W = 20
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_start,
   input  logic [CNT_W-1:0]    i_num_in,
   input  logic [CNT_W-1:0]    i_num_out,
   output logic                o_idle,
   output logic                o_done,
   output logic                o_node_ce,
   output logic [CNT_W-1:0]    o_node_addr,
   output logic                o_wegt_ce,
   output logic [ADDR_W-1:0]   o_wegt_addr,
   output logic [CNT_W-1:0]    o_bias_addr,
   output logic                o_core_run,
   output logic                o_core_valid,
   output logic                o_core_bias_en,
   input  logic [4*DATA_W-1:0] i_core_result,
   output logic                o_res_valid,
   output logic [4*DATA_W-1:0] o_res_data,
   output logic [CNT_W-1:0]    o_res_idx,
   input  logic                i_res_ready
);

   localparam int unsigned RES_W = 4 * DATA_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_OUT,
      S_DONE
   } state_t;

   state_t              state, state_n;
   logic [CNT_W-1:0]    num_in_q, num_in_n;
   logic [CNT_W-1:0]    num_out_q, num_out_n;
   logic [CNT_W-1:0]    in_cnt, in_cnt_n;
   logic [CNT_W-1:0]    out_cnt, out_cnt_n;
   logic [ADDR_W-1:0]   wbase, wbase_n;
   logic [ADDR_W-1:0]   wegt_addr, wegt_addr_n;
   logic                drain_cnt, drain_cnt_n;
   logic [RES_W-1:0]    res_data, res_data_n;

   logic                idle_q, done_q, ce_q, run_q, res_valid_q;
   logic                core_valid_q, bias_en_q;

   // State, counters and registered outputs; flag outputs follow the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         num_in_q     <= '0;
         num_out_q    <= '0;
         in_cnt       <= '0;
         out_cnt      <= '0;
         wbase        <= '0;
         wegt_addr    <= '0;
         drain_cnt    <= 1'b0;
         res_data     <= '0;
         idle_q       <= 1'b1;
         done_q       <= 1'b0;
         ce_q         <= 1'b0;
         run_q        <= 1'b0;
         res_valid_q  <= 1'b0;
         core_valid_q <= 1'b0;
         bias_en_q    <= 1'b0;
      end else begin
         state        <= state_n;
         num_in_q     <= num_in_n;
         num_out_q    <= num_out_n;
         in_cnt       <= in_cnt_n;
         out_cnt      <= out_cnt_n;
         wbase        <= wbase_n;
         wegt_addr    <= wegt_addr_n;
         drain_cnt    <= drain_cnt_n;
         res_data     <= res_data_n;
         idle_q       <= (state_n == S_IDLE);
         done_q       <= (state_n == S_DONE);
         ce_q         <= (state_n == S_RUN);
         run_q        <= (state_n == S_CLEAR);
         res_valid_q  <= (state_n == S_OUT);
         // Operands arrive one cycle after the read enable
         core_valid_q <= ce_q;
         bias_en_q    <= ce_q && (in_cnt == '0);
      end
   end

   // Next-state and counter update
   always_comb begin
      state_n     = state;
      num_in_n    = num_in_q;
      num_out_n   = num_out_q;
      in_cnt_n    = in_cnt;
      out_cnt_n   = out_cnt;
      wbase_n     = wbase;
      wegt_addr_n = wegt_addr;
      drain_cnt_n = drain_cnt;
      res_data_n  = res_data;

      case (state)
         S_IDLE: begin
            if (i_start) begin
               num_in_n  = i_num_in;
               num_out_n = i_num_out;
               out_cnt_n = '0;
               wbase_n   = '0;
               in_cnt_n  = '0;
               if ((i_num_in == '0) || (i_num_out == '0)) begin
                  state_n = S_DONE;
               end else begin
                  state_n = S_CLEAR;
               end
            end
         end
         S_CLEAR: begin
            in_cnt_n    = '0;
            wegt_addr_n = wbase;
            state_n     = S_RUN;
         end
         S_RUN: begin
            // Weight address tracks wbase + in_cnt incrementally
            in_cnt_n    = in_cnt + CNT_W'(1);
            wegt_addr_n = wegt_addr + ADDR_W'(1);
            if (in_cnt == (num_in_q - CNT_W'(1))) begin
               drain_cnt_n = 1'b0;
               state_n     = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Two cycles: last operand into the core, then accumulator settles
            drain_cnt_n = 1'b1;
            if (drain_cnt) begin
               res_data_n = i_core_result;
               state_n    = S_OUT;
            end
         end
         S_OUT: begin
            if (i_res_ready) begin
               if (out_cnt == (num_out_q - CNT_W'(1))) begin
                  state_n = S_DONE;
               end else begin
                  out_cnt_n = out_cnt + CNT_W'(1);
                  wbase_n   = wbase + ADDR_W'(num_in_q);
                  state_n   = S_CLEAR;
               end
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   assign o_idle         = idle_q;
   assign o_done         = done_q;
   assign o_node_ce      = ce_q;
   assign o_wegt_ce      = ce_q;
   assign o_node_addr    = in_cnt;
   assign o_wegt_addr    = wegt_addr;
   assign o_bias_addr    = out_cnt;
   assign o_core_run     = run_q;
   assign o_core_valid   = core_valid_q;
   assign o_core_bias_en = bias_en_q;
   assign o_res_valid    = res_valid_q;
   assign o_res_data     = res_data;
   assign o_res_idx      = out_cnt;

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Self-checking bench for fc_layer_ctrl with a behavioural MAC core and
// memories; expected neuron sums and address streams come from matrix-vector
// arithmetic and are consumed by a negedge monitor.
module tb_fc_layer_ctrl;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = 10;
   localparam int unsigned ADDR_W = 20;
   localparam int unsigned RES_W  = 4 * DATA_W;

   logic                clk = 1'b0;
   logic                reset;
   logic                i_start;
   logic [CNT_W-1:0]    i_num_in;
   logic [CNT_W-1:0]    i_num_out;
   logic                o_idle;
   logic                o_done;
   logic                o_node_ce;
   logic [CNT_W-1:0]    o_node_addr;
   logic                o_wegt_ce;
   logic [ADDR_W-1:0]   o_wegt_addr;
   logic [CNT_W-1:0]    o_bias_addr;
   logic                o_core_run;
   logic                o_core_valid;
   logic                o_core_bias_en;
   logic [RES_W-1:0]    i_core_result;
   logic                o_res_valid;
   logic [RES_W-1:0]    o_res_data;
   logic [CNT_W-1:0]    o_res_idx;
   logic                i_res_ready;

   fc_layer_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_start        (i_start),
      .i_num_in       (i_num_in),
      .i_num_out      (i_num_out),
      .o_idle         (o_idle),
      .o_done         (o_done),
      .o_node_ce      (o_node_ce),
      .o_node_addr    (o_node_addr),
      .o_wegt_ce      (o_wegt_ce),
      .o_wegt_addr    (o_wegt_addr),
      .o_bias_addr    (o_bias_addr),
      .o_core_run     (o_core_run),
      .o_core_valid   (o_core_valid),
      .o_core_bias_en (o_core_bias_en),
      .i_core_result  (i_core_result),
      .o_res_valid    (o_res_valid),
      .o_res_data     (o_res_data),
      .o_res_idx      (o_res_idx),
      .i_res_ready    (i_res_ready)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [CNT_W-1:0]  na;
      logic [ADDR_W-1:0] wa;
   } addr_t;

   typedef struct {
      logic [CNT_W-1:0] idx;
      logic [RES_W-1:0] data;
   } res_t;

   addr_t exp_addr[$];
   res_t  exp_res[$];

   // Behavioural memories and MAC core
   logic [DATA_W-1:0] node_mem [0:1023];
   logic [DATA_W-1:0] wegt_mem [0:4095];
   logic [DATA_W-1:0] bias_mem [0:1023];
   logic [DATA_W-1:0] node_q, wegt_q, bias_q;
   logic [RES_W-1:0]  acc;

   assign i_core_result = acc;

   always @(posedge clk) begin
      if (o_node_ce) node_q <= node_mem[o_node_addr];
      if (o_wegt_ce) wegt_q <= wegt_mem[o_wegt_addr[11:0]];
      bias_q <= bias_mem[o_bias_addr];
      if (reset || o_core_run)
         acc <= '0;
      else if (o_core_valid)
         acc <= acc + RES_W'(node_q) * RES_W'(wegt_q) + (o_core_bias_en ? RES_W'(bias_q) : RES_W'(0));
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Layer context shared with the monitor
   int  cur_ni = 0;
   int  cur_no = 0;
   int  valid_k = 0;
   bit  layer_nonzero = 0;
   int  final_hs_cyc = -10;
   bit  any_activity = 0;
   bit  stall_hold = 0;
   logic [RES_W-1:0] held_data;
   logic [CNT_W-1:0] held_idx;
   int  ready_mode = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Ready driver
   initial begin
      i_res_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       i_res_ready = 1'b1;
            1:       i_res_ready = 1'b0;
            default: i_res_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: scoreboard pops and stream invariants
   always @(negedge clk) begin
      if (!reset) begin
         if (o_node_ce || o_core_run) any_activity = 1;
         if (o_node_ce) begin
            check("wegt_ce_with_node_ce", 64'(o_wegt_ce), 64'd1);
            if (exp_addr.size() == 0) begin
               check("unexpected_ce", 64'(o_node_ce), 64'd0);
            end else begin
               addr_t a;
               a = exp_addr.pop_front();
               check("node_addr", 64'(o_node_addr), 64'(a.na));
               check("wegt_addr", 64'(o_wegt_addr), 64'(a.wa));
            end
         end
         if (o_core_valid && cur_ni > 0) begin
            check("bias_en_pos", 64'(o_core_bias_en), 64'((valid_k % cur_ni) == 0));
            valid_k++;
         end else if (o_core_bias_en) begin
            check("stray_bias_en", 64'(o_core_bias_en), 64'd0);
         end
         if (o_res_valid) begin
            check("no_ce_in_out", 64'(o_node_ce), 64'd0);
            if (stall_hold) begin
               check("stall_data_stable", 64'(o_res_data), 64'(held_data));
               check("stall_idx_stable", 64'(o_res_idx), 64'(held_idx));
            end
            if (i_res_ready) begin
               stall_hold = 0;
               if (exp_res.size() == 0) begin
                  check("unexpected_result", 64'(o_res_valid), 64'd0);
               end else begin
                  res_t r;
                  r = exp_res.pop_front();
                  check("res_idx", 64'(o_res_idx), 64'(r.idx));
                  check("res_data", 64'(o_res_data), 64'(r.data));
                  if (int'(r.idx) == cur_no - 1) final_hs_cyc = cyc;
               end
            end else begin
               stall_hold = 1;
               held_data  = o_res_data;
               held_idx   = o_res_idx;
            end
         end
         if (o_done && layer_nonzero)
            check("done_after_last_hs", 64'(cyc), 64'(final_hs_cyc + 1));
      end
   end

   // Fill memories, build expected streams, and pulse start
   task automatic start_layer(input int ni, input int no, input bit push);
      logic [RES_W-1:0] s;
      if (push) begin
         for (int i = 0; i < ni; i++) node_mem[i] = DATA_W'($urandom);
         for (int i = 0; i < ni * no; i++) wegt_mem[i] = DATA_W'($urandom);
         for (int o = 0; o < no; o++) bias_mem[o] = DATA_W'($urandom);
         for (int o = 0; o < no; o++) begin
            res_t r;
            s = RES_W'(bias_mem[o]);
            for (int i = 0; i < ni; i++) begin
               addr_t a;
               a.na = CNT_W'(i);
               a.wa = ADDR_W'(o * ni + i);
               exp_addr.push_back(a);
               s = s + RES_W'(node_mem[i]) * RES_W'(wegt_mem[o * ni + i]);
            end
            r.idx  = CNT_W'(o);
            r.data = s;
            exp_res.push_back(r);
         end
      end
      @(posedge clk);
      #1;
      cur_ni        = ni;
      cur_no        = no;
      valid_k       = 0;
      layer_nonzero = (ni != 0) && (no != 0);
      stall_hold    = 0;
      i_num_in      = CNT_W'(ni);
      i_num_out     = CNT_W'(no);
      i_start       = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max_cyc);
      bit seen = 0;
      for (int k = 0; k < max_cyc && !seen; k++) begin
         @(negedge clk);
         if (o_done) seen = 1;
      end
      check({name, "_done_seen"}, 64'(seen), 64'd1);
      @(negedge clk);
      check({name, "_done_one_cycle"}, 64'(o_done), 64'd0);
      check({name, "_idle_after_done"}, 64'(o_idle), 64'd1);
      check({name, "_addr_q_empty"}, 64'(exp_addr.size()), 64'd0);
      check({name, "_res_q_empty"}, 64'(exp_res.size()), 64'd0);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_idle"}, 64'(o_idle), 64'd1);
      check({name, "_done"}, 64'(o_done), 64'd0);
      check({name, "_node_ce"}, 64'(o_node_ce), 64'd0);
      check({name, "_wegt_ce"}, 64'(o_wegt_ce), 64'd0);
      check({name, "_core_run"}, 64'(o_core_run), 64'd0);
      check({name, "_core_valid"}, 64'(o_core_valid), 64'd0);
      check({name, "_bias_en"}, 64'(o_core_bias_en), 64'd0);
      check({name, "_res_valid"}, 64'(o_res_valid), 64'd0);
      check({name, "_node_addr"}, 64'(o_node_addr), 64'd0);
      check({name, "_wegt_addr"}, 64'(o_wegt_addr), 64'd0);
      check({name, "_bias_addr"}, 64'(o_bias_addr), 64'd0);
      check({name, "_res_data"}, 64'(o_res_data), 64'd0);
      check({name, "_res_idx"}, 64'(o_res_idx), 64'd0);
   endtask

   initial begin
      bit found;
      reset     = 1'b1;
      i_start   = 1'b0;
      i_num_in  = '0;
      i_num_out = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      reset = 1'b0;

      // 3 inputs x 2 outputs, always ready
      ready_mode = 0;
      start_layer(3, 2, 1);
      wait_done("l3x2", 200);

      // 1x1 cycle-exact latency
      start_layer(1, 1, 1);
      check("lat_c1_run", 64'(o_core_run), 64'd1);
      check("lat_c1_ce", 64'(o_node_ce), 64'd0);
      @(posedge clk); #1;
      check("lat_c2_ce", 64'(o_node_ce), 64'd1);
      check("lat_c2_run", 64'(o_core_run), 64'd0);
      @(posedge clk); #1;
      check("lat_c3_valid", 64'(o_core_valid), 64'd1);
      @(posedge clk); #1;
      check("lat_c4_res_valid", 64'(o_res_valid), 64'd0);
      @(posedge clk); #1;
      check("lat_c5_res_valid", 64'(o_res_valid), 64'd1);
      @(posedge clk); #1;
      check("lat_c6_done", 64'(o_done), 64'd1);
      @(posedge clk); #1;
      check("lat_c7_idle", 64'(o_idle), 64'd1);

      // Back-pressure for 10 cycles in OUT
      ready_mode = 1;
      start_layer(2, 2, 1);
      found = 0;
      for (int k = 0; k < 50 && !found; k++) begin
         @(negedge clk);
         if (o_res_valid) found = 1;
      end
      check("stall_reach_out", 64'(found), 64'd1);
      repeat (10) @(negedge clk);
      check("stall_still_valid", 64'(o_res_valid), 64'd1);
      ready_mode = 0;
      wait_done("stall", 200);

      // Zero-size layers finish immediately without touching memory
      any_activity = 0;
      start_layer(4, 0, 0);
      check("zero_out_done", 64'(o_done), 64'd1);
      start_layer(0, 3, 0);
      check("zero_in_done", 64'(o_done), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      check("zero_no_activity", 64'(any_activity), 64'd0);
      check("zero_idle", 64'(o_idle), 64'd1);

      // Reset in RUN at in_cnt=2 of the second neuron
      start_layer(5, 2, 1);
      found = 0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge clk);
         if (o_node_ce && o_node_addr == CNT_W'(2) && o_bias_addr == CNT_W'(1)) found = 1;
      end
      check("midreset_reach_run", 64'(found), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("midreset");
      reset = 1'b0;
      exp_addr.delete();
      exp_res.delete();
      stall_hold = 0;
      repeat (2) @(posedge clk);
      #1;
      check("midreset_no_resume", 64'(o_idle), 64'd1);
      start_layer(3, 1, 1);
      wait_done("after_reset", 200);

      // Reset dominates a simultaneous start
      @(posedge clk); #1;
      reset     = 1'b1;
      i_start   = 1'b1;
      i_num_in  = CNT_W'(2);
      i_num_out = CNT_W'(2);
      @(posedge clk); #1;
      reset   = 1'b0;
      i_start = 1'b0;
      check("rst_dom_idle", 64'(o_idle), 64'd1);
      @(posedge clk); #1;
      check("rst_dom_idle2", 64'(o_idle), 64'd1);
      check("rst_dom_no_run", 64'(o_core_run), 64'd0);

      // Start pulse during RUN is ignored
      start_layer(4, 2, 1);
      found = 0;
      for (int k = 0; k < 50 && !found; k++) begin
         @(negedge clk);
         if (o_node_ce && o_node_addr == CNT_W'(1)) found = 1;
      end
      check("ign_reach_run", 64'(found), 64'd1);
      i_num_in  = CNT_W'(7);
      i_num_out = CNT_W'(7);
      i_start   = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      wait_done("ignore_start", 300);

      // Randomized layers with random back-pressure
      ready_mode = 2;
      for (int l = 0; l < 6; l++) begin
         start_layer($urandom_range(1, 8), $urandom_range(1, 5), 1);
         wait_done("rand", 2000);
      end
      ready_mode = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global time limit
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fc_layer_ctrl.md
FC_LAYER_CTRL -- requirements
Module: fc_layer_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the core operand width; the result width is 4*DATA_W.
REQ-002 SHALL have parameter CNT_W, default 10, meaning the width of the node counters and of the node/bias addresses.
REQ-003 SHALL have parameter ADDR_W, default 20, meaning the weight address width.
REQ-004 SHALL use one clock; reset is synchronous and active-high: clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-005 SHALL provide ports:
- i_start  in  1  start-layer pulse
- i_num_in  in  CNT_W  input node count
- i_num_out  in  CNT_W  output node count
- o_idle  out  1  high in IDLE
- o_done  out  1  one-cycle layer-complete pulse
- o_node_ce  out  1  node memory read enable
- o_node_addr  out  CNT_W  node memory address
- o_wegt_ce  out  1  weight memory read enable
- o_wegt_addr  out  ADDR_W  weight memory address
- o_bias_addr  out  CNT_W  bias memory address, equal to the current output index
- o_core_run  out  1  accumulator clear to the MAC core
- o_core_valid  out  1  operand-valid to the MAC core
- o_core_bias_en  out  1  bias gate; high only with the first operand of each neuron
- i_core_result  in  4*DATA_W  core accumulator value
- o_res_valid  out  1  neuron result valid
- o_res_data  out  4*DATA_W  neuron result
- o_res_idx  out  CNT_W  output neuron index
- i_res_ready  in  1  result accepted

Function
REQ-006 SHALL implement the FSM states IDLE, CLEAR, RUN, DRAIN, OUT and DONE.
REQ-007 In IDLE, o_idle SHALL be 1, and i_start SHALL latch i_num_in and i_num_out.
- If either count is 0: go to DONE.
- Otherwise: go to CLEAR with out_cnt=0 and wbase=0.
REQ-008 i_start SHALL be ignored in every state other than IDLE.
REQ-009 CLEAR SHALL last exactly 1 cycle, with o_core_run=1 and in_cnt=0, and then go to RUN.
REQ-010 RUN SHALL last exactly num_in cycles. Each cycle it SHALL drive:
- o_node_ce=o_wegt_ce=1
- o_node_addr=in_cnt
- o_wegt_addr=wbase+in_cnt, computed modulo 2^ADDR_W with no multiplier
- in_cnt incremented
When in_cnt==num_in-1, RUN SHALL go to DRAIN.
REQ-011 Memory read latency is 1 cycle. o_core_valid SHALL equal o_node_ce delayed by 1 register.
REQ-012 o_core_bias_en SHALL be 1 only in the cycle after the ce issued for in_cnt==0.
REQ-013 DRAIN SHALL last exactly 2 cycles. On its last cycle, i_core_result SHALL be captured into o_res_data, and the state SHALL go to OUT.
REQ-014 In OUT, o_res_valid SHALL be 1, with o_res_data and o_res_idx=out_cnt held stable until i_res_ready=1.
REQ-015 An OUT handshake SHALL complete in the cycle where o_res_valid & i_res_ready.
- If out_cnt==num_out-1: go to DONE.
- Otherwise: out_cnt+=1, wbase+=num_in, and go to CLEAR.
REQ-016 DONE SHALL assert o_done=1 for exactly 1 cycle and then go to IDLE.
REQ-017 o_node_ce and o_wegt_ce SHALL be 0 outside RUN. o_core_run SHALL be 0 outside CLEAR.
REQ-018 Per-neuron latency from CLEAR entry to o_res_valid SHALL be num_in+3 cycles, with stalls only from i_res_ready.
REQ-019 o_bias_addr SHALL equal out_cnt in every state.

Reset
REQ-020 In the cycle after reset=1, the state SHALL be IDLE, including when reset occurs mid-layer.
REQ-021 On reset, every counter, wbase and the captured result SHALL be 0.
REQ-022 On reset, every output SHALL be 0 except o_idle, which SHALL be 1.
REQ-023 Reset SHALL dominate i_start in the same cycle.
REQ-024 No layer state SHALL persist across reset; a new i_start is required to resume.

Verification
REQ-025 Start with num_in=3, num_out=2 and i_res_ready=1 -> required response:
- o_wegt_addr sequence 0,1,2 then 3,4,5
- o_core_bias_en at positions 1 and 4 of the o_core_valid pulses
- o_res_idx 0 then 1
- o_done 1 cycle after the second handshake
REQ-026 Start with num_in=1, num_out=1 -> o_core_run at cycle 1, ce at cycle 2, o_res_valid at cycle 5, o_done at cycle 6.
REQ-027 Hold i_res_ready=0 for 10 cycles in OUT -> o_res_data and o_res_idx stable, no ce issued, then progress resumes on ready.
REQ-028 i_start with num_out=0 -> o_done the next cycle, and no ce or o_core_run ever asserted.
REQ-029 Assert reset=1 in RUN at in_cnt=2 -> next cycle o_idle=1 and all other outputs 0; a fresh i_start restarts from address 0.
REQ-030 i_start pulsed during RUN -> ignored, with the address sequence unaffected.
